// File: rtl/periph_bus_bridge.sv
// -----------------------------------------------------------------------------
// periph_bus_bridge
//
// Bridges the core's peripheral data port onto N_SLAVES fixed address windows
// above PERIPHERAL_BASE. Each accepted core request is decoded, then either
// runs one registered valid/ready access to the selected slave or is rejected
// as a decode/alignment error. Every request ends with exactly one d_ready
// pulse. Write data and byte strobes are shifted onto the addressed lanes.
// Reads return the whole doubleword unshifted.
//
// Optional feature (compile-time macro):
//   PBB_TIMEOUT_EN  - abort a slave access after TIMEOUT_CYCLES cycles without
//                     p_ready. The access then completes with bus_err=1.
//
// Ports:
//   clock         in   1            rising-edge clock
//   reset_n       in   1            asynchronous active-low reset
//   d_addr        in   64           core byte address
//   d_wdata       in   64           core store data, right-justified
//   d_store_type  in   3            0 read, 1 byte, 2 half, 3 word, 4 dword
//   d_valid       in   1            core request (sampled only in IDLE)
//   d_rdata       out  64           read doubleword, valid while d_ready=1
//   d_ready       out  1            one-cycle completion pulse
//   p_sel         out  N_SLAVES     one-hot slave select during an access
//   p_valid       out  1            slave request
//   p_write       out  1            1 = write access
//   p_addr        out  SLOT_BITS    in-window offset, doubleword aligned
//   p_wdata       out  64           lane-shifted write data
//   p_wstrb       out  8            byte enables, 0 on reads
//   p_rdata       in   N_SLAVES*64  per-slave read data, slice k = slave k
//   p_ready       in   N_SLAVES     per-slave accept/complete
//   bus_err       out  1            error pulse, coincident with d_ready
// -----------------------------------------------------------------------------
module periph_bus_bridge #(
   parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
   parameter int unsigned N_SLAVES        = 4,
   parameter int unsigned SLOT_BITS       = 12,
   parameter int unsigned TIMEOUT_CYCLES  = 255
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [63:0]             d_addr,
   input  logic [63:0]             d_wdata,
   input  logic [2:0]              d_store_type,
   input  logic                    d_valid,
   output logic [63:0]             d_rdata,
   output logic                    d_ready,
   output logic [N_SLAVES-1:0]     p_sel,
   output logic                    p_valid,
   output logic                    p_write,
   output logic [SLOT_BITS-1:0]    p_addr,
   output logic [63:0]             p_wdata,
   output logic [7:0]              p_wstrb,
   input  logic [N_SLAVES*64-1:0]  p_rdata,
   input  logic [N_SLAVES-1:0]     p_ready,
   output logic                    bus_err
);

   typedef enum logic [2:0] {
      ST_NONE  = 3'd0,
      ST_BYTE  = 3'd1,
      ST_HALF  = 3'd2,
      ST_WORD  = 3'd3,
      ST_DWORD = 3'd4
   } mem_store_type_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [63:0]          WINDOW_SPAN = 64'(N_SLAVES) << SLOT_BITS;
   localparam logic [SLOT_BITS-1:0] OFF_MASK    = ~SLOT_BITS'(7);

   state_t                r_state;
   state_t                w_next;
   logic [N_SLAVES-1:0]   r_sel;
   logic                  r_write;
   logic [SLOT_BITS-1:0]  r_addr;
   logic [63:0]           r_wdata;
   logic [7:0]            r_wstrb;
   logic [63:0]           r_rdata;
   logic                  r_err;

   logic [63:0]           w_off;
   logic [2:0]            w_slot;
   logic [2:0]            w_lane;
   logic                  w_in_range;
   logic                  w_aligned;
   logic                  w_decode_ok;
   logic [7:0]            w_strb;
   logic [N_SLAVES-1:0]   w_sel_dec;
   logic                  w_slave_ready;
   logic [63:0]           w_slv_rdata;
   logic                  w_timeout;

   // ---------------------------------------------------------------- decode
   // Subtraction only wraps when d_addr < BASE, and that case is already
   // excluded by the first term of the range test.
   assign w_off       = d_addr - PERIPHERAL_BASE;
   assign w_slot      = w_off[SLOT_BITS +: 3];
   assign w_lane      = d_addr[2:0];
   assign w_in_range  = (d_addr >= PERIPHERAL_BASE) && (w_off < WINDOW_SPAN);
   assign w_decode_ok = w_in_range && w_aligned;

   // NOTE: every signal written in an always_comb gets a default before any
   // branch; otherwise an unassigned path infers a latch.
   always_comb begin
      w_aligned = 1'b1;
      w_strb    = 8'h00;
      case (mem_store_type_t'(d_store_type))
         ST_NONE:  w_strb = 8'h00;
         ST_BYTE:  w_strb = 8'h01 << w_lane;
         ST_HALF: begin
            w_aligned = (w_lane[0] == 1'b0);
            w_strb    = 8'h03 << w_lane;
         end
         ST_WORD: begin
            w_aligned = (w_lane[1:0] == 2'b00);
            w_strb    = 8'h0F << w_lane;
         end
         ST_DWORD: begin
            w_aligned = (w_lane == 3'b000);
            w_strb    = 8'hFF;
         end
         // Reserved size codes cannot be mapped to lanes; reject them
         // through the error path so that no slave sees them.
         default:  w_aligned = 1'b0;
      endcase
   end

   always_comb begin
      w_sel_dec = '0;
      for (int k = 0; k < int'(N_SLAVES); k++) begin
         if (w_slot == 3'(k)) w_sel_dec[k] = 1'b1;
      end
   end

   // Only the latched slave's ready and read data are considered. Other
   // slaves are masked out by r_sel.
   assign w_slave_ready = |(p_ready & r_sel);

   always_comb begin
      w_slv_rdata = '0;
      for (int k = 0; k < int'(N_SLAVES); k++) begin
         if (r_sel[k]) w_slv_rdata = p_rdata[k*64 +: 64];
      end
   end

   // --------------------------------------------------------------- timeout
`ifdef PBB_TIMEOUT_EN
   localparam int unsigned TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 32) ? 32 : TO_RAW);

   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_to_cnt <= '0;
      end else if (r_state != S_ACCESS) begin
         r_to_cnt <= '0;
      end else if (!w_slave_ready) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   // The count is cleared on entry, so it reads TIMEOUT_CYCLES-1 during the
   // last permitted ACCESS cycle. A p_ready in that cycle still wins because
   // the FSM tests w_slave_ready first.
   assign w_timeout = (r_state == S_ACCESS) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
   assign w_timeout        = 1'b0;
`endif

   // ------------------------------------------------------------------- FSM
   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples values from before the clock edge regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (d_valid) w_next = w_decode_ok ? S_ACCESS : S_RESP;
         end
         S_ACCESS: begin
            if (w_slave_ready || w_timeout) w_next = S_RESP;
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sel   <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (d_valid) begin
                  if (w_decode_ok) begin
                     r_sel   <= w_sel_dec;
                     r_write <= (d_store_type != ST_NONE);
                     r_addr  <= w_off[SLOT_BITS-1:0] & OFF_MASK;
                     r_wdata <= d_wdata << {w_lane, 3'b000};
                     r_wstrb <= w_strb;
                     r_err   <= 1'b0;
                  end else begin
                     r_sel   <= '0;
                     r_rdata <= '1;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_ACCESS: begin
               if (w_slave_ready) begin
                  r_rdata <= r_write ? 64'd0 : w_slv_rdata;
                  r_err   <= 1'b0;
               end else if (w_timeout) begin
                  r_rdata <= '1;
                  r_err   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------- outputs
   // Slave-facing strobes are qualified by the ACCESS state, so they drop in
   // the same edge that ends the access.
   assign p_valid = (r_state == S_ACCESS);
   assign p_sel   = p_valid ? r_sel : '0;
   assign p_write = p_valid & r_write;
   assign p_addr  = r_addr;
   assign p_wdata = r_wdata;
   assign p_wstrb = r_wstrb;
   assign d_ready = (r_state == S_RESP);
   assign d_rdata = r_rdata;
   assign bus_err = d_ready & r_err;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_periph_bus_bridge
//
// Directed self-checking bench for periph_bus_bridge (N_SLAVES=4,
// SLOT_BITS=12, TIMEOUT_CYCLES=8). Each request goes through xfer(), which
// plays the slave side. xfer() then records the slave-side snapshot, the
// latency, the number of p_valid cycles and the response. Expected values are
// hand-computed constants in the test sequence. The timeout cases are built
// only when PBB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_periph_bus_bridge;

   logic          clock;
   logic          reset_n;
   logic [63:0]   d_addr;
   logic [63:0]   d_wdata;
   logic [2:0]    d_store_type;
   logic          d_valid;
   logic [63:0]   d_rdata;
   logic          d_ready;
   logic [3:0]    p_sel;
   logic          p_valid;
   logic          p_write;
   logic [11:0]   p_addr;
   logic [63:0]   p_wdata;
   logic [7:0]    p_wstrb;
   logic [255:0]  p_rdata;
   logic [3:0]    p_ready;
   logic          bus_err;

   int n_checks = 0;
   int n_bad    = 0;

   // Snapshot and response recorded by xfer()
   logic [3:0]    s_sel;
   logic          s_write;
   logic [11:0]   s_addr;
   logic [63:0]   s_wdata;
   logic [7:0]    s_wstrb;
   logic [63:0]   s_rdata;
   logic          s_err;
   int            s_lat;
   int            s_pv_cnt;

   periph_bus_bridge #(
      .PERIPHERAL_BASE (64'h2000_0000),
      .N_SLAVES        (4),
      .SLOT_BITS       (12),
      .TIMEOUT_CYCLES  (8)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_store_type (d_store_type),
      .d_valid      (d_valid),
      .d_rdata      (d_rdata),
      .d_ready      (d_ready),
      .p_sel        (p_sel),
      .p_valid      (p_valid),
      .p_write      (p_write),
      .p_addr       (p_addr),
      .p_wdata      (p_wdata),
      .p_wstrb      (p_wstrb),
      .p_rdata      (p_rdata),
      .p_ready      (p_ready),
      .bus_err      (bus_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_d_ready"}, 64'(d_ready), 64'd0);
      check({pfx, "_d_rdata"}, d_rdata,      64'd0);
      check({pfx, "_p_sel"},   64'(p_sel),   64'd0);
      check({pfx, "_p_valid"}, 64'(p_valid), 64'd0);
      check({pfx, "_p_write"}, 64'(p_write), 64'd0);
      check({pfx, "_p_addr"},  64'(p_addr),  64'd0);
      check({pfx, "_p_wdata"}, p_wdata,      64'd0);
      check({pfx, "_p_wstrb"}, 64'(p_wstrb), 64'd0);
      check({pfx, "_bus_err"}, 64'(bus_err), 64'd0);
   endtask

   // One core request. The slave whose bit is set in exp_sel raises p_ready
   // in ACCESS cycle dly (0-based) and returns rd. Every other slave holds
   // p_ready high throughout and returns junk, and both must be ignored. The
   // core drops d_valid and scrambles d_addr right after capture.
   task automatic xfer(input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [2:0] st, input logic [3:0] exp_sel,
                       input int dly, input logic [63:0] rd);
      bit got;
      for (int k = 0; k < 4; k++)
         p_rdata[k*64 +: 64] = exp_sel[k] ? rd : (64'hBAD0_0000_0000_0000 | 64'(k));
      @(posedge clock); #1;
      d_addr       = addr;
      d_wdata      = wdata;
      d_store_type = st;
      d_valid      = 1'b1;
      p_ready      = 4'b0000;
      got      = 1'b0;
      s_lat    = 0;
      s_pv_cnt = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clock); #1;
         if (k == 1) begin
            d_valid      = 1'b0;
            d_addr       = 64'h0;
            d_wdata      = 64'h0;
            d_store_type = 3'd0;
            s_sel   = p_sel;
            s_write = p_write;
            s_addr  = p_addr;
            s_wdata = p_wdata;
            s_wstrb = p_wstrb;
         end
         if (p_valid) s_pv_cnt++;
         if (d_ready) begin
            got     = 1'b1;
            s_lat   = k;
            s_rdata = d_rdata;
            s_err   = bus_err;
            p_ready = 4'b0000;
            break;
         end
         p_ready = (k - 1 == dly) ? exp_sel : ~exp_sel;
      end
      check("xfer_done", 64'(got), 64'd1);
      @(posedge clock); #1;
      check("ready_one_cycle", 64'(d_ready), 64'd0);
   endtask

   initial begin
      reset_n      = 1'b0;
      d_addr       = '0;
      d_wdata      = '0;
      d_store_type = '0;
      d_valid      = 1'b0;
      p_rdata      = '0;
      p_ready      = '0;

      // ---- reset state
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;

      // ---- read slave 1, slave answers in its third ACCESS cycle
      xfer(64'h2000_1010, 64'h0, 3'd0, 4'b0010, 2, 64'h1234);
      check("rd1_sel",   64'(s_sel),   64'h2);
      check("rd1_addr",  64'(s_addr),  64'h010);
      check("rd1_wstrb", 64'(s_wstrb), 64'h00);
      check("rd1_write", 64'(s_write), 64'd0);
      check("rd1_rdata", s_rdata,      64'h1234);
      check("rd1_err",   64'(s_err),   64'd0);
      check("rd1_lat",   64'(s_lat),   64'd4);
      check("rd1_pv",    64'(s_pv_cnt),64'd3);

      // ---- byte store, slave 0 answers immediately
      xfer(64'h2000_0005, 64'hAB, 3'd1, 4'b0001, 0, 64'h5555);
      check("sb_sel",   64'(s_sel),   64'h1);
      check("sb_wstrb", 64'(s_wstrb), 64'h20);
      check("sb_wdata", s_wdata,      64'h0000_AB00_0000_0000);
      check("sb_write", 64'(s_write), 64'd1);
      check("sb_addr",  64'(s_addr),  64'h000);
      check("sb_rdata", s_rdata,      64'd0);
      check("sb_lat",   64'(s_lat),   64'd2);

      // ---- word store to upper lanes
      xfer(64'h2000_0004, 64'hDEAD_BEEF, 3'd3, 4'b0001, 1, 64'h0);
      check("sw_wstrb", 64'(s_wstrb), 64'hF0);
      check("sw_wdata", s_wdata,      64'hDEAD_BEEF_0000_0000);
      check("sw_err",   64'(s_err),   64'd0);

      // ---- half store at the last halfword of the last window
      xfer(64'h2000_3FFE, 64'h1234, 3'd2, 4'b1000, 0, 64'h0);
      check("sh_sel",   64'(s_sel),   64'h8);
      check("sh_addr",  64'(s_addr),  64'hFF8);
      check("sh_wstrb", 64'(s_wstrb), 64'hC0);
      check("sh_wdata", s_wdata,      64'h1234_0000_0000_0000);

      // ---- dword store to slave 2
      xfer(64'h2000_2008, 64'h0123_4567_89AB_CDEF, 3'd4, 4'b0100, 0, 64'h0);
      check("sd_sel",   64'(s_sel),   64'h4);
      check("sd_addr",  64'(s_addr),  64'h008);
      check("sd_wstrb", 64'(s_wstrb), 64'hFF);
      check("sd_wdata", s_wdata,      64'h0123_4567_89AB_CDEF);

      // ---- decode and alignment errors: no slave access, one-cycle latency
      xfer(64'h1FFF_FFF8, 64'h0, 3'd0, 4'b0000, 0, 64'h0);
      check("below_pv",    64'(s_pv_cnt), 64'd0);
      check("below_lat",   64'(s_lat),    64'd1);
      check("below_err",   64'(s_err),    64'd1);
      check("below_rdata", s_rdata,       64'hFFFF_FFFF_FFFF_FFFF);

      xfer(64'h2000_4000, 64'h0, 3'd0, 4'b0000, 0, 64'h0);
      check("above_pv",    64'(s_pv_cnt), 64'd0);
      check("above_lat",   64'(s_lat),    64'd1);
      check("above_err",   64'(s_err),    64'd1);
      check("above_rdata", s_rdata,       64'hFFFF_FFFF_FFFF_FFFF);

      xfer(64'h1_2000_0000, 64'h0, 3'd0, 4'b0000, 0, 64'h0);
      check("hi64_err", 64'(s_err),    64'd1);
      check("hi64_pv",  64'(s_pv_cnt), 64'd0);

      xfer(64'h2000_0002, 64'h77, 3'd3, 4'b0000, 0, 64'h0);
      check("misw_err", 64'(s_err),    64'd1);
      check("misw_pv",  64'(s_pv_cnt), 64'd0);
      check("misw_lat", 64'(s_lat),    64'd1);

      xfer(64'h2000_0001, 64'h77, 3'd2, 4'b0000, 0, 64'h0);
      check("mish_err", 64'(s_err), 64'd1);

      // ---- good read right after an error
      xfer(64'h2000_0000, 64'h0, 3'd0, 4'b0001, 0, 64'hCAFE_F00D_0000_0001);
      check("rd0_rdata", s_rdata,    64'hCAFE_F00D_0000_0001);
      check("rd0_err",   64'(s_err), 64'd0);

`ifdef PBB_TIMEOUT_EN
      // ---- silent slave: p_valid for exactly 8 cycles, then error
      xfer(64'h2000_1000, 64'h0, 3'd0, 4'b0010, 1000, 64'h99);
      check("to_pv",    64'(s_pv_cnt), 64'd8);
      check("to_lat",   64'(s_lat),    64'd9);
      check("to_err",   64'(s_err),    64'd1);
      check("to_rdata", s_rdata,       64'hFFFF_FFFF_FFFF_FFFF);

      // ---- p_ready on the 8th cycle wins over the timeout
      xfer(64'h2000_1000, 64'h0, 3'd0, 4'b0010, 7, 64'h99);
      check("to8_pv",    64'(s_pv_cnt), 64'd8);
      check("to8_err",   64'(s_err),    64'd0);
      check("to8_rdata", s_rdata,       64'h99);
`endif

      // ---- reset in the middle of an access
      @(posedge clock); #1;
      d_addr       = 64'h2000_2018;
      d_wdata      = 64'h1111_2222_3333_4444;
      d_store_type = 3'd4;
      d_valid      = 1'b1;
      p_ready      = 4'b0000;
      @(posedge clock); #1;
      d_valid = 1'b0;
      check("mid_pvalid", 64'(p_valid), 64'd1);
      check("mid_pwstrb", 64'(p_wstrb), 64'hFF);
      #2 reset_n = 1'b0;
      #1;
      check_all_zero("midrst");
      begin
         int seen = 0;
         p_ready = 4'b0100;
         for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            if (d_ready) seen++;
         end
         p_ready = 4'b0000;
         reset_n = 1'b1;
         for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            if (d_ready) seen++;
         end
         check("midrst_no_ready", 64'(seen), 64'd0);
      end

      xfer(64'h2000_2010, 64'h0, 3'd0, 4'b0100, 1, 64'hABCD_EF01);
      check("post_rdata", s_rdata,      64'hABCD_EF01);
      check("post_err",   64'(s_err),   64'd0);
      check("post_lat",   64'(s_lat),   64'd3);
      check("post_addr",  64'(s_addr),  64'h010);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
